// File: rtl/ctrl_pipe_n.sv
// Control-bundle pipeline: STAGES registered slots behind decode with per-stage
// stall/flush, upstream stall propagation, bubble insertion and a retire counter.
module ctrl_pipe_n #(
    parameter int                WIDTH     = 32,
    parameter int                STAGES    = 3,
    parameter logic [STAGES-1:0] GATE_MASK = {STAGES{1'b0}},
    parameter int                CNT_W     = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [WIDTH-1:0]          in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [STAGES-1:0]         stall,
    input  logic [STAGES-1:0]         flush,
    output logic [STAGES*WIDTH-1:0]   stage_data,
    output logic [STAGES-1:0]         stage_valid,
    output logic [CNT_W-1:0]          retire_cnt
);

    logic [STAGES-1:0] hold_s;
    logic [STAGES-1:0] prev_hold_s;
    logic [STAGES-1:0] prev_valid_s;
    logic [WIDTH-1:0]  prev_data_s [STAGES];

    logic [STAGES-1:0] valid_q, valid_d;
    logic [WIDTH-1:0]  data_q [STAGES];
    logic [WIDTH-1:0]  data_d [STAGES];
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // Hold chain: a stall freezes its own stage and every stage before it.
    always_comb begin
        hold_s = '0;
        hold_s[STAGES-1] = stall[STAGES-1];
        for (int i = STAGES - 2; i >= 0; i--) begin
            hold_s[i] = stall[i] | hold_s[i+1];
        end
    end

    // Upstream source of each stage; stage 0 is fed by decode and never bubbles.
    always_comb begin
        prev_hold_s     = '0;
        prev_valid_s    = '0;
        for (int i = 0; i < STAGES; i++) begin
            prev_data_s[i] = '0;
        end
        prev_valid_s[0] = in_valid;
        prev_data_s[0]  = in_valid ? in_data : '0;
        for (int i = 1; i < STAGES; i++) begin
            prev_hold_s[i]  = hold_s[i-1];
            prev_valid_s[i] = valid_q[i-1];
            prev_data_s[i]  = data_q[i-1];
        end
    end

    // Per-stage next state: flush beats hold, hold beats bubble, else advance.
    always_comb begin
        valid_d = '0;
        for (int i = 0; i < STAGES; i++) begin
            data_d[i] = '0;
            if (flush[i]) begin
                valid_d[i] = 1'b0;
                data_d[i]  = '0;
            end else if (hold_s[i]) begin
                valid_d[i] = valid_q[i];
                data_d[i]  = data_q[i];
            end else if (prev_hold_s[i]) begin
                valid_d[i] = 1'b0;
                data_d[i]  = '0;
            end else begin
                valid_d[i] = prev_valid_s[i];
                data_d[i]  = prev_data_s[i];
            end
        end
    end

    // Retire counter advances when the last stage hands off a real bundle.
    always_comb begin
        if (valid_q[STAGES-1] & ~stall[STAGES-1] & ~flush[STAGES-1]) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            cnt_q   <= '0;
            for (int i = 0; i < STAGES; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            for (int i = 0; i < STAGES; i++) begin
                data_q[i] <= data_d[i];
            end
        end
    end

    // Output view: masked stages read as empty in the same cycle they are flushed.
    always_comb begin
        stage_data  = '0;
        stage_valid = '0;
        for (int i = 0; i < STAGES; i++) begin
            if (GATE_MASK[i] & flush[i]) begin
                stage_data[i*WIDTH +: WIDTH] = '0;
                stage_valid[i]               = 1'b0;
            end else begin
                stage_data[i*WIDTH +: WIDTH] = data_q[i];
                stage_valid[i]               = valid_q[i];
            end
        end
    end

    assign in_ready   = ~hold_s[0];
    assign retire_cnt = cnt_q;

endmodule

// File: tb/tb_ctrl_pipe_n.sv
// Self-checking bench for ctrl_pipe_n (WIDTH=8, STAGES=3, GATE_MASK=3'b100, CNT_W=4):
// directed scenarios with literal expectations plus a randomized run against a model.
module tb_ctrl_pipe_n;

    localparam int         W  = 8;
    localparam int         S  = 3;
    localparam int         CW = 4;
    localparam logic [2:0] GM = 3'b100;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [W-1:0]  in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [S-1:0]  stall = '0;
    logic [S-1:0]  flush = '0;
    logic [S*W-1:0] stage_data;
    logic [S-1:0]  stage_valid;
    logic [CW-1:0] retire_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    ctrl_pipe_n #(.WIDTH(W), .STAGES(S), .GATE_MASK(GM), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .stall(stall), .flush(flush),
        .stage_data(stage_data), .stage_valid(stage_valid), .retire_cnt(retire_cnt)
    );

    // Reference model: stages up to the highest stalled one freeze, the next one bubbles.
    logic [S*W-1:0] m_data  = '0;
    logic [S-1:0]   m_valid = '0;
    logic [CW-1:0]  m_cnt   = '0;

    function automatic logic [CW+S+S*W-1:0] mdl_next();
        int             hi = -1;
        logic [S*W-1:0] nd = '0;
        logic [S-1:0]   nv = '0;
        logic [CW-1:0]  nc;
        for (int j = 0; j < S; j++) if (stall[j]) hi = j;
        for (int i = 0; i < S; i++) begin
            if (rst || flush[i]) begin
                nv[i] = 1'b0;
            end else if (i <= hi) begin
                nv[i] = m_valid[i];
                nd[i*W +: W] = m_data[i*W +: W];
            end else if (hi >= 0 && i == hi + 1) begin
                nv[i] = 1'b0;
            end else if (i == 0) begin
                nv[0] = in_valid;
                nd[W-1:0] = in_valid ? in_data : 8'h00;
            end else begin
                nv[i] = m_valid[i-1];
                nd[i*W +: W] = m_data[(i-1)*W +: W];
            end
        end
        if (rst) nc = 4'd0;
        else if (m_valid[S-1] && !stall[S-1] && !flush[S-1]) nc = m_cnt + 4'd1;
        else nc = m_cnt;
        return {nc, nv, nd};
    endfunction

    always @(posedge clk) begin
        {m_cnt, m_valid, m_data} <= mdl_next();
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [S*W-1:0] exp_data();
        logic [S*W-1:0] d = m_data;
        for (int i = 0; i < S; i++) if (GM[i] && flush[i]) d[i*W +: W] = 8'h00;
        return d;
    endfunction

    function automatic logic [S-1:0] exp_valid();
        logic [S-1:0] v = m_valid;
        for (int i = 0; i < S; i++) if (GM[i] && flush[i]) v[i] = 1'b0;
        return v;
    endfunction

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready", 32'(in_ready), 32'(stall == 3'b000));
            chk("stage_valid", 32'(stage_valid), 32'(exp_valid()));
            chk("stage_data", 32'(stage_data), 32'(exp_data()));
            chk("retire_cnt", 32'(retire_cnt), 32'(m_cnt));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [7:0] sd(input int i);
        return stage_data[i*W +: W];
    endfunction

    initial begin
        // Reset state
        tick();
        chk("rst_valid", 32'(stage_valid), 32'h0);
        chk("rst_data", 32'(stage_data), 32'h0);
        chk("rst_cnt", 32'(retire_cnt), 32'h0);
        chk("rst_ready", 32'(in_ready), 32'h1);
        rst = 1'b0;
        chk_en = 1'b1;

        // Stream 0x11, 0x22, 0x33
        in_valid = 1'b1; in_data = 8'h11; tick();
        in_data = 8'h22; tick();
        in_data = 8'h33; tick();
        in_valid = 1'b0; in_data = 8'h00;
        chk("stream_s2_a", 32'(sd(2)), 32'h11);
        tick(); chk("stream_s2_b", 32'(sd(2)), 32'h22);
        tick(); chk("stream_s2_c", 32'(sd(2)), 32'h33);
        tick(); chk("stream_cnt", 32'(retire_cnt), 32'd3);

        // Stall stage 1 for two cycles while 0xA1 sits there
        in_valid = 1'b1; in_data = 8'hA1; tick();
        in_data = 8'hB2; tick();
        in_data = 8'hC3; stall = 3'b010;
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("stall_ready", 32'(in_ready), 32'h0);
            chk("stall_s1", 32'(sd(1)), 32'hA1);
            chk("stall_s0", 32'(sd(0)), 32'hB2);
            chk("stall_s2_bubble", 32'({stage_valid[2], sd(2)}), 32'h0);
        end
        stall = 3'b000; tick();
        chk("resume_s2", 32'({stage_valid[2], sd(2)}), 32'h1A1);
        chk("resume_s1", 32'({stage_valid[1], sd(1)}), 32'h1B2);
        chk("resume_s0", 32'({stage_valid[0], sd(0)}), 32'h1C3);
        in_valid = 1'b0; in_data = 8'h00;
        tick(); tick(); tick();
        chk("stall_cnt", 32'(retire_cnt), 32'd6);

        // Flush beats stall on stage 0; simultaneous input is dropped
        in_valid = 1'b1; in_data = 8'h5C; tick();
        chk("flush_pre", 32'({stage_valid[0], sd(0)}), 32'h15C);
        stall = 3'b001; flush = 3'b001; in_data = 8'h77; tick();
        chk("flush_s0", 32'({stage_valid[0], sd(0)}), 32'h0);
        stall = 3'b000; flush = 3'b000; in_valid = 1'b0; in_data = 8'h00; tick();
        chk("flush_no77", 32'({stage_valid[1], sd(1)}), 32'h0);

        // Gated flush on stage 2
        in_valid = 1'b1; in_data = 8'hF0; tick();
        in_valid = 1'b0; in_data = 8'h00; tick(); tick();
        chk("gate_pre", 32'({stage_valid[2], sd(2)}), 32'h1F0);
        flush = 3'b100; #1;
        chk("gate_same_cycle", 32'({stage_valid[2], sd(2)}), 32'h0);
        tick();
        chk("gate_no_retire", 32'(retire_cnt), 32'd6);
        flush = 3'b000; #1;
        chk("gate_cleared", 32'({stage_valid[2], sd(2)}), 32'h0);

        // Reset mid-stream with stall[2] high
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_data = 8'(8'h40 + k); tick();
        end
        stall = 3'b100; rst = 1'b1; tick();
        chk("rst_mid_valid", 32'(stage_valid), 32'h0);
        chk("rst_mid_data", 32'(stage_data), 32'h0);
        chk("rst_mid_cnt", 32'(retire_cnt), 32'h0);
        chk("rst_mid_ready", 32'(in_ready), 32'h0);
        rst = 1'b0; stall = 3'b000;

        // Counter wrap: 17 retirements on a 4-bit counter
        for (int k = 0; k < 17; k++) begin
            in_data = 8'(k + 1); tick();
        end
        in_valid = 1'b0; in_data = 8'h00;
        tick(); tick(); tick();
        chk("wrap_cnt", 32'(retire_cnt), 32'd1);

        // Invalid input with garbage data
        in_valid = 1'b0; in_data = 8'hFF; tick();
        chk("invalid_s0", 32'({stage_valid[0], sd(0)}), 32'h0);

        // Randomized traffic
        for (int k = 0; k < 3000; k++) begin
            for (int j = 0; j < S; j++) begin
                stall[j] = ($urandom_range(0, 99) < 12);
                flush[j] = ($urandom_range(0, 99) < 7);
            end
            in_valid = ($urandom_range(0, 99) < 70);
            in_data  = 8'($urandom);
            rst      = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst = 1'b0; stall = '0; flush = '0; in_valid = 1'b0;
        tick();
        chk_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ctrl_pipe_n.md
# ctrl_pipe_n

Parametrised control-signal pipeline carrying decoded control bundles from decode through N downstream stages. Each stage has per-stage stall and flush, a valid bit, and automatic bubble insertion. Stalls propagate upstream. Selected stages can have their outputs combinationally gated by flush in the same cycle. A retire counter tracks instructions leaving the last stage. It replaces hand-built per-stage flop chains in the CPU controller and sits between the main/ALU decoders and the E/M/W datapath consumers.

## Interface
- WIDTH, 32: control bundle width in bits (≥1).
- STAGES, 3: number of pipeline stages (≥1). Stage 0 is the first register after decode.
- GATE_MASK, {STAGES{1'b0}}: bit i set means stage i outputs are forced to zero combinationally while flush[i]=1.
- CNT_W, 32: retire counter width.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_data  in  WIDTH  decoded control bundle.
- in_valid  in  1  in_data holds a real instruction.
- in_ready  out  1  stage 0 can accept input this cycle; equals ~hold[0].
- stall  in  STAGES  stall request for each stage.
- flush  in  STAGES  clear request for each stage.
- stage_data  out  STAGES*WIDTH  flattened stage contents; stage i occupies bits [i*WIDTH +: WIDTH].
- stage_valid  out  STAGES  valid bit of each stage.
- retire_cnt  out  CNT_W  number of retired bundles.

## Operation
- Hold chain (combinational):
  - hold[STAGES-1] = stall[STAGES-1].
  - hold[i] = stall[i] | hold[i+1].
  - A stall at any stage freezes that stage and every earlier stage.
- Per-stage next state, in priority order:
  1. rst: valid=0, data=0.
  2. flush[i]: valid=0, data=0. Flush wins over hold.
  3. hold[i]: keep current contents.
  4. i>0 and hold[i-1]: insert a bubble (valid=0, data=0).
  5. Otherwise advance:
     - stage i takes stage i-1's valid and data.
     - stage 0 takes valid=in_valid and data = in_valid ? in_data : 0.
- Invalid stages always hold data=0. Consumers may use data bits directly without qualifying them by valid.
- Input acceptance: an input is accepted only when in_valid & in_ready & ~flush[0].
  - An input offered while in_ready=0 is not captured.
  - The upstream holds in_data until in_ready returns.
- Output gating: for each stage i with GATE_MASK[i]=1 and flush[i]=1:
  - stage_data slice and stage_valid[i] read 0 in the same cycle.
  - The register itself clears on the next edge.
  - Stages with GATE_MASK[i]=0 present the raw register value.
- Retire counter:
  - Increments by 1 on each edge where valid[STAGES-1] & ~stall[STAGES-1] & ~flush[STAGES-1].
  - Wraps from 2^CNT_W-1 to 0.
  - Reset clears it to 0.
- STAGES=1: hold[0]=stall[0], and no bubble rule applies.

## Timing
- Reset values:
  - stage_data=0, stage_valid=0, retire_cnt=0.
  - in_ready=~stall-derived hold[0], purely combinational.
- Latency:
  - A bundle accepted at edge t appears on stage 0 after edge t.
  - With no stalls it appears on stage k after edge t+k.
  - Throughput is one bundle per cycle.
- Stall:
  - The stalled stage and all earlier stages freeze for exactly the cycles stall is high.
  - The stage just downstream of the highest stalled stage receives one bubble per stalled cycle.
- Simultaneous events:
  - flush[i] together with hold[i]: stage i clears.
  - Upstream stages that are held remain frozen.
  - flush[i] with stall[j], j>i: stage i clears, and stages above i stay frozen.
- Reset asserted mid-operation clears every stage and the counter on that edge, regardless of stall or flush.
- All outputs except in_ready and gated stages are registered.

## Test plan
- Stream: WIDTH=8, STAGES=3. Present 0x11, 0x22, 0x33 on consecutive cycles with no stall or flush -> stage 2 shows 0x11, 0x22, 0x33 on edges 3, 4, 5, and retire_cnt ends at 3.
- Stall: stall[1]=1 for 2 cycles while 0xA1 is in stage 1 -> stage 0 and stage 1 frozen, in_ready=0, stage 2 receives two bubbles (valid=0, data=0x00), then flow resumes in order with nothing lost.
- Flush priority: flush[0]=1 and stall[0]=1 with stage 0 holding 0x5C -> after the edge stage_valid[0]=0 and data=0x00. A simultaneous in_valid with 0x77 is not captured.
- Gating: GATE_MASK=3'b100, stage 2 valid with 0xF0, assert flush[2] -> same cycle stage 2 reads 0x00 and valid=0, retire_cnt does not increment, and the register clears at the next edge.
- Wrap and reset: CNT_W=4, retire 17 valid bundles -> retire_cnt=1. Assert rst mid-stream with stall[2]=1 -> every output is 0 after one edge.
- Invalid input: in_valid=0 with in_data=0xFF -> stage 0 shows valid=0 and data=0x00.
